// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: FSM state encoding, default
// word width and SCLK edge classification by clock polarity.
package spi_pkg;

    localparam int SPI_DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // Leading edge is the transition away from the idle level CPOL.
    function automatic logic lead_edge(input bit cpol, input logic rise, input logic fall);
        return cpol ? fall : rise;
    endfunction

    function automatic logic trail_edge(input bit cpol, input logic rise, input logic fall);
        return cpol ? rise : fall;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall detection
// against one further registered copy of the synchronised level.
module spi_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_chain[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
            r_prev  <= RESET_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_prev  <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/MOSI/SSB in the system clock domain, shifts
// words MSB first through one shared shifter, one-entry TX buffer, RX pulse.
//
// state  | meaning
// IDLE   | SSB high, MISO disabled, waiting for SSB fall
// ACTIVE | SSB low, sampling MOSI and driving MISO on SCLK edges
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DEFAULT_WIDTH,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  ssb,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic w_sclk_rise, w_sclk_fall;
    logic w_ssb_rise, w_ssb_fall;
    logic w_mosi_s;
    logic w_lead, w_trail, w_sample, w_shift;
    logic [DATA_WIDTH-1:0] w_load_word;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    spi_state_t             r_state;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_tx_buf;
    logic                   r_tx_ready;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid;
    logic                   r_tx_underrun;
    logic                   r_miso;
    logic                   r_miso_oe;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .clock   (clock),
        .reset_n (reset_n),
        .i_async (sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_async (ssb),
        .o_rise  (w_ssb_rise),
        .o_fall  (w_ssb_fall)
    );

    // MOSI needs only the level, delayed by the same depth as SCLK so the
    // sample edge and the data it samples stay aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_lead   = lead_edge(CPOL, w_sclk_rise, w_sclk_fall);
    assign w_trail  = trail_edge(CPOL, w_sclk_rise, w_sclk_fall);
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead  : w_trail;

    assign w_load_word = r_tx_ready ? '0 : r_tx_buf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_tx_buf      <= '0;
            r_tx_ready    <= 1'b1;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (tx_valid && r_tx_ready) begin
                r_tx_buf   <= tx_data;
                r_tx_ready <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_ssb_fall) begin
                        r_state   <= ACTIVE;
                        r_miso_oe <= 1'b1;
                        r_bit_cnt <= '0;
                        if (!CPHA) begin
                            r_shift       <= w_load_word;
                            r_miso        <= w_load_word[DATA_WIDTH-1];
                            r_tx_underrun <= r_tx_ready;
                            if (!r_tx_ready) r_tx_ready <= 1'b1;
                        end
                    end
                end

                ACTIVE: begin
                    if (w_ssb_rise) begin
                        r_state   <= IDLE;
                        r_miso_oe <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_sample) begin
                        r_shift <= {r_shift[DATA_WIDTH-2:0], w_mosi_s};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_rx_data  <= {r_shift[DATA_WIDTH-2:0], w_mosi_s};
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (w_shift) begin
                        // A shift edge seen with the counter at zero opens a new
                        // word: the first leading edge (CPHA=1) or the trailing
                        // edge right after a completed word (CPHA=0).
                        if (r_bit_cnt == '0) begin
                            r_shift       <= w_load_word;
                            r_miso        <= w_load_word[DATA_WIDTH-1];
                            r_tx_underrun <= r_tx_ready;
                            if (!r_tx_ready) r_tx_ready <= 1'b1;
                        end else begin
                            r_miso <= r_shift[DATA_WIDTH-1];
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = r_miso_oe;
    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per CPOL/CPHA mode, a bus-master
// model per instance and hand-computed expected words.
module tb_spi_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] sclk_a, ssb_a, mosi_a, txv_a;
    logic [3:0] miso_a, oe_a, txr_a, rxv_a, und_a;
    logic [7:0] txd_a [4];
    logic [7:0] rxd_a [4];

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt  [4] = '{default: 0};
    int und_cnt [4] = '{default: 0};
    logic [7:0] rx_seen [4][64];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .DATA_WIDTH  (8),
            .CPOL        (g >= 2),
            .CPHA        (g % 2 == 1),
            .SYNC_STAGES (2)
        ) u_dut (
            .clock       (clk),
            .reset_n     (rst_n),
            .sclk        (sclk_a[g]),
            .ssb         (ssb_a[g]),
            .mosi        (mosi_a[g]),
            .miso        (miso_a[g]),
            .miso_oe     (oe_a[g]),
            .tx_data     (txd_a[g]),
            .tx_valid    (txv_a[g]),
            .tx_ready    (txr_a[g]),
            .rx_data     (rxd_a[g]),
            .rx_valid    (rxv_a[g]),
            .tx_underrun (und_a[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rxv_a[k]) begin
                rx_seen[k][rx_cnt[k] % 64] = rxd_a[k];
                rx_cnt[k]++;
            end
            if (und_a[k]) und_cnt[k]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic push_tx(input int m, input logic [7:0] d);
        int budget = 200;
        while (!txr_a[m] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("push_timeout", txr_a[m], 1);
        txd_a[m] = d;
        txv_a[m] = 1'b1;
        @(negedge clk);
        txv_a[m] = 1'b0;
    endtask

    task automatic start(input int m);
        ssb_a[m] = 1'b0;
        half();
    endtask

    task automatic stop(input int m);
        half();
        ssb_a[m] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic cpol, cpha;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi_a[m] = mo[7-i];
                half();
                mi = {mi[6:0], miso_a[m]};
                sclk_a[m] = ~cpol;
                half();
                sclk_a[m] = cpol;
            end else begin
                sclk_a[m] = ~cpol;
                mosi_a[m] = mo[7-i];
                half();
                mi = {mi[6:0], miso_a[m]};
                sclk_a[m] = cpol;
                half();
            end
        end
    endtask

    initial begin
        logic [7:0] mi, mi2;
        int base, ubase;

        rst_n  = 1'b0;
        sclk_a = 4'b1100;
        ssb_a  = 4'hF;
        mosi_a = 4'h0;
        txv_a  = 4'h0;
        for (int k = 0; k < 4; k++) txd_a[k] = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_miso", miso_a[0], 0);
        check("rst_oe", oe_a[0], 0);
        check("rst_tx_ready", txr_a[0], 1);
        check("rst_rx_data", rxd_a[0], 8'h00);
        check("rst_rx_valid", rxv_a[0], 0);
        check("rst_underrun", und_a[0], 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0 single frame
        push_tx(0, 8'hA5);
        check("t1_ready_low", txr_a[0], 0);
        base = rx_cnt[0];
        start(0);
        check("t1_oe", oe_a[0], 1);
        xfer(0, 8'h3C, 8, mi);
        stop(0);
        check("t1_miso_word", mi, 8'hA5);
        check("t1_rx_data", rxd_a[0], 8'h3C);
        check("t1_rx_pulses", rx_cnt[0] - base, 1);
        check("t1_ready_back", txr_a[0], 1);
        check("t1_oe_off", oe_a[0], 0);

        // Back-to-back words under one SSB low
        push_tx(0, 8'h55);
        base = rx_cnt[0];
        start(0);
        fork
            xfer(0, 8'h01, 8, mi);
            push_tx(0, 8'hAA);
        join
        xfer(0, 8'hFF, 8, mi2);
        stop(0);
        check("t2_miso_w0", mi, 8'h55);
        check("t2_miso_w1", mi2, 8'hAA);
        check("t2_rx_pulses", rx_cnt[0] - base, 2);
        check("t2_rx_w0", rx_seen[0][base % 64], 8'h01);
        check("t2_rx_w1", rx_seen[0][(base + 1) % 64], 8'hFF);

        // Empty buffer: underrun at SSB fall and again at the end-of-word load
        ubase = und_cnt[0];
        start(0);
        check("t3_underrun_start", und_cnt[0] - ubase, 1);
        xfer(0, 8'hC3, 8, mi);
        stop(0);
        check("t3_miso_zero", mi, 8'h00);
        check("t3_rx_data", rxd_a[0], 8'hC3);
        check("t3_underrun_total", und_cnt[0] - ubase, 2);

        // Abort after 5 bits; SSB rise coincides with an SCLK trailing edge
        base = rx_cnt[0];
        start(0);
        xfer(0, 8'hF0, 5, mi);
        ssb_a[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("t4_oe_off", oe_a[0], 0);
        repeat (8) @(negedge clk);
        check("t4_no_rx", rx_cnt[0] - base, 0);
        check("t4_rx_hold", rxd_a[0], 8'hC3);
        push_tx(0, 8'h5A);
        base = rx_cnt[0];
        start(0);
        xfer(0, 8'h81, 8, mi);
        stop(0);
        check("t4_miso_next", mi, 8'h5A);
        check("t4_rx_next", rxd_a[0], 8'h81);
        check("t4_rx_pulses", rx_cnt[0] - base, 1);

        // All four modes
        for (int m = 0; m < 4; m++) begin
            push_tx(m, 8'h69);
            base = rx_cnt[m];
            start(m);
            xfer(m, 8'h96, 8, mi);
            stop(m);
            check($sformatf("t5_m%0d_miso", m), mi, 8'h69);
            check($sformatf("t5_m%0d_rx", m), rxd_a[m], 8'h96);
            check($sformatf("t5_m%0d_pulses", m), rx_cnt[m] - base, 1);
        end

        // Reset in the middle of a word
        push_tx(0, 8'h33);
        start(0);
        xfer(0, 8'h7E, 3, mi);
        rst_n = 1'b0;
        #1;
        check("t6_rst_oe", oe_a[0], 0);
        check("t6_rst_miso", miso_a[0], 0);
        check("t6_rst_ready", txr_a[0], 1);
        check("t6_rst_rx_data", rxd_a[0], 8'h00);
        @(negedge clk);
        ssb_a[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push_tx(0, 8'h24);
        base = rx_cnt[0];
        start(0);
        xfer(0, 8'h7E, 8, mi);
        stop(0);
        check("t6_miso_after", mi, 8'h24);
        check("t6_rx_after", rxd_a[0], 8'h7E);
        check("t6_rx_pulses", rx_cnt[0] - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
